// File: rtl/mmio_uart_tx_if.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_if
// Bus-side control signals of the p18240 memory interface, as seen by the
// UART transmitter.
//   memAddr : 16-bit address from MAR
//   re_L    : active-low read strobe
//   we_L    : active-low write strobe
// The shared dataBus is a resolved tristate net and is carried as a plain
// inout port of the responder, so the bus driver stays visible at the
// module boundary where the net is resolved.
// ---------------------------------------------------------------------------
interface mmio_uart_tx_if;
    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;

    modport master (output memAddr, output re_L, output we_L);
    modport slave  (input  memAddr, input  re_L, input  we_L);
endinterface

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter on the p18240 bus, 3-word window:
//   BASE+0 TXDATA  (W: push byte, R: 0)
//   BASE+1 STATUS  (R: {count[6:4], ovf, busy, full, empty}; W bit3: clear ovf)
//   BASE+2 BAUDDIV (R/W: cycles per bit minus 1)
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : memAddr / re_L / we_L (slave modport)
//   dataBus      : shared tristate data bus, driven only on decoded reads
//   tx           : registered serial output, idle high
//   busy         : registered, high while a frame is on the wire
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR   = 16'h2100,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic               clock,
    input  logic               reset,
    mmio_uart_tx_if.slave      bus,
    inout  wire         [15:0] dataBus,
    output logic               tx,
    output logic               busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    // ---------------- bus decode ----------------
    logic [15:0] offs;
    logic        hit, wr_en, rd_en;
    logic [15:0] rdata;

    // Unsigned offset makes the window test a single compare.
    assign offs  = bus.memAddr - BASE_ADDR;
    assign hit   = (offs < 16'd3);
    assign wr_en = hit && !bus.we_L;
    assign rd_en = hit && !bus.re_L && bus.we_L;  // write wins if both low

    // ---------------- registers ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q;
    logic [15:0]   div_q;

    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic empty, full, pop, push_req, push;
    logic [3:0] cnt_ext;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign pop      = (state_q == IDLE) && !empty;
    assign push_req = wr_en && (offs[1:0] == 2'd0);
    // A full FIFO still takes the byte when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign cnt_ext  = 4'(cnt_q);

    // ---------------- read mux ----------------
    always_comb begin
        rdata = 16'h0000;
        case (offs[1:0])
            2'd1:    rdata = {9'd0, cnt_ext[2:0], ovf_q, (state_q != IDLE), full, empty};
            2'd2:    rdata = div_q;
            default: rdata = 16'h0000;
        endcase
    end

    assign dataBus = rd_en ? rdata : 16'hzzzz;

    // ---------------- FIFO / control registers ----------------
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= dataBus[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
        end else begin
            cnt_q <= cnt_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_req && !push)
                ovf_q <= 1'b1;
            else if (wr_en && (offs[1:0] == 2'd1) && dataBus[3])
                ovf_q <= 1'b0;
            if (wr_en && (offs[1:0] == 2'd2))
                div_q <= dataBus;
        end
    end

    // ---------------- transmit FSM ----------------
    // baud_q counts down the current bit; it is reloaded from div_q only at
    // bit boundaries, so a BAUDDIV write never stretches the running bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = 3'd0;
                    baud_d  = div_q;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_q == 16'd0)
                    state_d = IDLE;
                else
                    baud_d = baud_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so tx/busy change on
        // the same edge as the state they describe.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
// Register vectors from a table, hand sequences for the timing corners, and
// random bursts checked against a cycle-level waveform model of 8N1 frames.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mmio_uart_tx_if bus_if ();
    wire  [15:0] dataBus;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_dat = 16'h0000;
    logic        tx, busy;

    assign dataBus = tb_drv ? tb_dat : 16'hzzzz;

    mmio_uart_tx #(
        .BASE_ADDR  (16'h2100),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus_if),
        .dataBus(dataBus),
        .tx     (tx),
        .busy   (busy)
    );

    localparam int DEPTH = 4;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- waveform model ----------------
    // Each entry is the expected {tx, busy} for one clock cycle; the monitor
    // consumes one entry per cycle, sampling mid-cycle.
    logic [1:0] expq[$];
    logic [1:0] mon_e;
    string      stream_name = "none";

    always @(negedge clock) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk({stream_name, " tx/busy"}, {14'd0, tx, busy}, {14'd0, mon_e});
        end
    end

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) expq.push_back(2'b10);
    endtask

    // lens[0] start, lens[1..8] data bits LSB first, lens[9] stop
    task automatic add_frame_l(input logic [7:0] b, input int lens[10]);
        for (int c = 0; c < lens[0]; c++) expq.push_back(2'b01);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < lens[1+i]; c++) expq.push_back({b[i], 1'b1});
        for (int c = 0; c < lens[9]; c++) expq.push_back(2'b11);
    endtask

    task automatic add_frame(input logic [7:0] b, input int d);
        int lens[10];
        for (int i = 0; i < 10; i++) lens[i] = d + 1;
        add_frame_l(b, lens);
    endtask

    // Frames of bytes[0..n-1] back to back, one idle cycle between frames.
    task automatic add_frames(input logic [7:0] bytes[8], input int n, input int d);
        for (int i = 0; i < n; i++) begin
            add_frame(bytes[i], d);
            add_idle(1);
        end
        add_idle(3);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (expq.size() > 0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        chk({name, " drain"}, 16'(expq.size()), 16'd0);
        expq.delete();
        @(posedge clock);
        #1;
    endtask

    // ---------------- bus tasks (called at posedge+1) ----------------
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus_if.memAddr = a;
        bus_if.we_L    = 1'b0;
        bus_if.re_L    = 1'b1;
        tb_dat         = d;
        tb_drv         = 1'b1;
        @(posedge clock);
        #1;
        bus_if.we_L    = 1'b1;
        tb_drv         = 1'b0;
        bus_if.memAddr = 16'h0000;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        bus_if.memAddr = a;
        bus_if.re_L    = 1'b0;
        #2;
        chk(name, dataBus, exp);
        @(posedge clock);
        #1;
        bus_if.re_L    = 1'b1;
        bus_if.memAddr = 16'h0000;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] addr;
        logic        re_n;
        logic        we_n;
        logic        drv;
        logic [15:0] wdat;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[14];

    logic [7:0] bytes[8];
    int         lens[10];
    int         d, n, acc, stuck;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus_if.memAddr = 16'h0000;
        bus_if.re_L    = 1'b1;
        bus_if.we_L    = 1'b1;

        vt[0]  = '{16'h2101, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vt[1]  = '{16'h2102, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd433};
        vt[2]  = '{16'h2100, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[3]  = '{16'h2000, 1'b0, 1'b1, 1'b1, 16'h5A5A, 1'b1, 16'h5A5A};
        vt[4]  = '{16'h2103, 1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b1, 16'hA5A5};
        vt[5]  = '{16'h2102, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000};
        vt[6]  = '{16'h2102, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234};
        vt[7]  = '{16'h2102, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b1, 16'h0055};
        vt[8]  = '{16'h2102, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0055};
        vt[9]  = '{16'h2101, 1'b1, 1'b0, 1'b1, 16'hFFF7, 1'b0, 16'h0000};
        vt[10] = '{16'h2101, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vt[11] = '{16'h20FF, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
        vt[12] = '{16'h2103, 1'b1, 1'b0, 1'b1, 16'h0077, 1'b0, 16'h0000};
        vt[13] = '{16'h2102, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0055};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx_held", 16'(tx), 16'h0001);
        reset = 1'b0;
        chk("rst_tx", 16'(tx), 16'h0001);
        chk("rst_busy", 16'(busy), 16'h0000);

        // ---- register vectors ----
        for (int i = 0; i < 14; i++) begin
            bus_if.memAddr = vt[i].addr;
            bus_if.re_L    = vt[i].re_n;
            bus_if.we_L    = vt[i].we_n;
            tb_drv         = vt[i].drv;
            tb_dat         = vt[i].wdat;
            #2;
            if (vt[i].chk) chk($sformatf("vec%0d", i), dataBus, vt[i].exp);
            @(posedge clock);
            #1;
            bus_if.re_L    = 1'b1;
            bus_if.we_L    = 1'b1;
            tb_drv         = 1'b0;
            bus_if.memAddr = 16'h0000;
        end

        // ---- single frame 0xA5 at BAUDDIV=3, STATUS around the pop ----
        stream_name = "a5";
        wr(16'h2102, 16'd3);
        wr(16'h2100, 16'h00A5);
        add_idle(1);
        add_frame(8'hA5, 3);
        add_idle(3);
        rd_chk("stat_before_pop", 16'h2101, 16'h0010);
        rd_chk("stat_after_pop", 16'h2101, 16'h0005);
        wait_drain("a5");

        // ---- six writes at BAUDDIV=0: one popped, four queued, one dropped ----
        stream_name = "burst6";
        wr(16'h2102, 16'd0);
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            wr(16'h2100, {8'h00, bytes[i]});
            if (i == 0) begin
                add_idle(1);
                add_frames(bytes, 5, 0);
            end
        end
        rd_chk("stat_full_ovf", 16'h2101, 16'h004E);
        wait_drain("burst6");
        rd_chk("stat_ovf_idle", 16'h2101, 16'h0009);
        wr(16'h2101, 16'h0008);
        rd_chk("stat_ovf_clr", 16'h2101, 16'h0001);

        // ---- push into a full FIFO on the pop edge is accepted ----
        stream_name = "fullpop";
        bytes = '{8'hC1, 8'h3E, 8'h80, 8'h01, 8'hF0, 8'h0F, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            wr(16'h2100, {8'h00, bytes[i]});
            if (i == 0) begin
                add_idle(1);
                add_frames(bytes, 6, 0);
            end
        end
        // first frame: START entry at E1+1, idle cycle is E1+11..E1+12
        repeat (7) @(posedge clock);
        #1;
        wr(16'h2100, {8'h00, bytes[5]});
        rd_chk("stat_full_pop", 16'h2101, 16'h0046);
        wait_drain("fullpop");
        rd_chk("stat_fullpop_end", 16'h2101, 16'h0001);

        // ---- BAUDDIV 7 -> 1 written in the middle of bit 2 ----
        stream_name = "divchg";
        wr(16'h2102, 16'd7);
        wr(16'h2100, 16'h0055);
        lens = '{8, 8, 8, 8, 2, 2, 2, 2, 2, 2};
        add_idle(1);
        add_frame_l(8'h55, lens);
        add_idle(3);
        repeat (27) @(posedge clock);
        #1;
        wr(16'h2102, 16'd1);
        wait_drain("divchg");

        // ---- random bursts against the model ----
        // Only the first byte pops during a burst (a frame outlasts it), so
        // the FIFO keeps the next DEPTH bytes and drops the rest.
        for (int it = 0; it < 4; it++) begin
            stream_name = $sformatf("rand%0d", it);
            d = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 6));
            acc = (n < DEPTH + 1) ? n : DEPTH + 1;
            for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
            wr(16'h2102, 16'(d));
            for (int i = 0; i < n; i++) begin
                wr(16'h2100, {8'h00, bytes[i]});
                if (i == 0) begin
                    add_idle(1);
                    add_frames(bytes, acc, d);
                end
            end
            wait_drain(stream_name);
            rd_chk({stream_name, " stat"}, 16'h2101, (n > DEPTH + 1) ? 16'h0009 : 16'h0001);
            wr(16'h2101, 16'h0008);
        end

        // ---- reset during DATA bit 4 with two bytes queued ----
        wr(16'h2102, 16'd1);
        bytes = '{8'hEF, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) wr(16'h2100, {8'h00, bytes[i]});
        // START at E1+1, 2 cycles per bit: bit 4 occupies E1+11..E1+13
        repeat (9) @(posedge clock);
        #1;
        chk("pre_rst_bit4", 16'(tx), 16'(bytes[0][4]));
        chk("pre_rst_busy", 16'(busy), 16'h0001);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_tx", 16'(tx), 16'h0001);
        chk("midrst_busy", 16'(busy), 16'h0000);
        rd_chk("midrst_stat", 16'h2101, 16'h0001);
        rd_chk("midrst_div", 16'h2102, 16'd433);
        stuck = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) stuck++;
        end
        chk("midrst_quiet", 16'(stuck), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
